// File: rtl/pattern_detector_moore_if.sv
// Bundle of the serial-stream, pattern-programming and match-report signals
// for pattern_detector_moore. The master drives the stream and the controls;
// the slave (the detector) returns the match pulse and the match count.
interface pattern_detector_moore_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             a;
    logic             valid;
    logic             load;
    logic [PAT_W-1:0] pattern;
    logic             overlap;
    logic             y;
    logic [CNT_W-1:0] match_count;
    logic             count_sat;

    modport master (
        output a, valid, load, pattern, overlap,
        input  y, match_count, count_sat
    );

    modport slave (
        input  a, valid, load, pattern, overlap,
        output y, match_count, count_sat
    );
endinterface

// File: rtl/pattern_detector_moore.sv
// Serial bit-pattern detector, Moore style. Bits qualified by valid are
// shifted into a history register; once PAT_W bits are held and the history
// equals the active pattern, a one-cycle registered match pulse is raised and
// a saturating match counter advances. The pattern and overlap mode can be
// reprogrammed at runtime with load, which also clears detection state.
module pattern_detector_moore #(
    parameter int               PAT_W     = 4,
    parameter int               CNT_W     = 8,
    parameter logic [PAT_W-1:0] RESET_PAT = 4'b1011,
    parameter logic             RESET_OVL = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    pattern_detector_moore_if.slave   bus
);

    // fill counts 0..PAT_W inclusive, so it needs one extra code point.
    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  shreg;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0]  pat_reg;
    logic              ovl_reg;
    logic              y_r;
    logic [CNT_W-1:0]  cnt_r;

    logic [PAT_W-1:0]  ns;
    logic [FILL_W-1:0] nf;
    logic              hit;
    logic              cnt_full;

    // Candidate next history, next fill level and match decision for a valid bit.
    always_comb begin
        ns  = {shreg[PAT_W-2:0], bus.a};
        nf  = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
        hit = (nf == FILL_FULL) && (ns == pat_reg);
    end

    assign cnt_full = &cnt_r;

    // Detection state, programmed configuration and registered match outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg   <= '0;
            fill    <= '0;
            pat_reg <= RESET_PAT;
            ovl_reg <= RESET_OVL;
            y_r     <= 1'b0;
            cnt_r   <= '0;
        end else if (bus.load) begin
            // A bit presented alongside load is deliberately dropped: the new
            // pattern starts from an empty history.
            pat_reg <= bus.pattern;
            ovl_reg <= bus.overlap;
            shreg   <= '0;
            fill    <= '0;
            y_r     <= 1'b0;
            cnt_r   <= '0;
        end else if (bus.valid) begin
            shreg <= ns;
            if (hit) begin
                y_r <= 1'b1;
                if (!cnt_full) begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
                // Without overlap the matched bits are consumed, so the next
                // match must be built from PAT_W fresh bits.
                fill <= ovl_reg ? nf : '0;
            end else begin
                y_r  <= 1'b0;
                fill <= nf;
            end
        end else begin
            y_r <= 1'b0;
        end
    end

    assign bus.y           = y_r;
    assign bus.match_count = cnt_r;
    assign bus.count_sat   = cnt_full;

endmodule

// File: tb/tb_pattern_detector_moore.sv
// Testbench for pattern_detector_moore: two instances (default counter width
// and a 2-bit counter) driven by directed vectors. Each stimulus edge pushes
// its hand-computed expected outputs into a per-instance queue; independent
// monitors pop and compare on the falling edge.
module tb_pattern_detector_moore;

    logic clk;
    logic reset;

    pattern_detector_moore_if #(.PAT_W(4), .CNT_W(8)) ia ();
    pattern_detector_moore_if #(.PAT_W(4), .CNT_W(2)) ib ();

    pattern_detector_moore #(.PAT_W(4), .CNT_W(8)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ia.slave)
    );

    pattern_detector_moore #(.PAT_W(4), .CNT_W(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ib.slave)
    );

    typedef struct {
        logic  y;
        int    cnt;
        logic  sat;
        string nm;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, act=running req=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input string what, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s.%s: actual=%0d required=%0d", nm, what, act, req);
        end
    endtask

    // Scoreboard monitor for the default-width instance.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            chk(e.nm, "y",   int'(ia.y),           int'(e.y));
            chk(e.nm, "cnt", int'(ia.match_count), e.cnt);
            chk(e.nm, "sat", int'(ia.count_sat),   int'(e.sat));
        end
    end

    // Scoreboard monitor for the 2-bit-counter instance.
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (qb.size() > 0) begin
            e = qb.pop_front();
            chk(e.nm, "y",   int'(ib.y),           int'(e.y));
            chk(e.nm, "cnt", int'(ib.match_count), e.cnt);
            chk(e.nm, "sat", int'(ib.count_sat),   int'(e.sat));
        end
    end

    task automatic push(input int d, input logic ey, input int ec, input string nm);
        exp_t e;
        e.y   = ey;
        e.cnt = ec;
        e.nm  = nm;
        if (d == 0) begin
            e.sat = (ec == 255);
            qa.push_back(e);
        end else begin
            e.sat = (ec == 3);
            qb.push_back(e);
        end
    endtask

    // One clock edge of stimulus on instance d, with its expected result.
    task automatic step(input int d, input logic ld, input logic [3:0] pat,
                        input logic ovl, input logic v, input logic bit_a,
                        input logic ey, input int ec, input string nm);
        @(negedge clk);
        if (d == 0) begin
            ia.load = ld; ia.pattern = pat; ia.overlap = ovl;
            ia.valid = v; ia.a = bit_a;
        end else begin
            ib.load = ld; ib.pattern = pat; ib.overlap = ovl;
            ib.valid = v; ib.a = bit_a;
        end
        @(posedge clk);
        push(d, ey, ec, nm);
    endtask

    task automatic bit_in(input int d, input logic bit_a, input logic ey,
                          input int ec, input string nm);
        step(d, 1'b0, 4'b0000, 1'b0, 1'b1, bit_a, ey, ec, nm);
    endtask

    task automatic idle(input int d, input logic bit_a, input int ec, input string nm);
        step(d, 1'b0, 4'b0000, 1'b0, 1'b0, bit_a, 1'b0, ec, nm);
    endtask

    task automatic do_load(input int d, input logic [3:0] pat, input logic ovl,
                           input logic v, input logic bit_a, input string nm);
        step(d, 1'b1, pat, ovl, v, bit_a, 1'b0, 0, nm);
    endtask

    // Short reset pulse entirely within the low phase of the clock; only an
    // asynchronous reset can act on it.
    task automatic pulse_reset();
        @(negedge clk);
        ia.valid = 1'b0; ia.load = 1'b0;
        ib.valid = 1'b0; ib.load = 1'b0;
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        @(posedge clk);
        push(0, 1'b0, 0, "rst_mid");
    endtask

    int b2[7] = '{1, 0, 1, 1, 0, 1, 1};
    int y2[7] = '{0, 0, 0, 1, 0, 0, 1};
    int c2[7] = '{0, 0, 0, 1, 1, 1, 2};
    int y3[7] = '{0, 0, 0, 1, 0, 0, 0};
    int c3[7] = '{0, 0, 0, 1, 1, 1, 1};
    int b7[7] = '{0, 1, 1, 0, 1, 1, 0};
    int y7[7] = '{0, 0, 0, 1, 0, 0, 1};
    int c7[7] = '{0, 0, 0, 1, 1, 1, 2};
    int y5[8] = '{0, 0, 0, 1, 1, 1, 1, 1};
    int c5[8] = '{0, 0, 0, 1, 2, 3, 3, 3};

    initial begin
        reset = 1'b1;
        ia.a = 1'b0; ia.valid = 1'b0; ia.load = 1'b0; ia.pattern = '0; ia.overlap = 1'b0;
        ib.a = 1'b0; ib.valid = 1'b0; ib.load = 1'b0; ib.pattern = '0; ib.overlap = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state.
        idle(0, 1'b1, 0, "rst_a");
        idle(1, 1'b1, 0, "rst_b");

        // Reset pattern 1011 with overlap: matches after bits 4 and 7.
        for (int i = 0; i < 7; i++)
            bit_in(0, b2[i][0], y2[i][0], c2[i], $sformatf("ovl_b%0d", i + 1));
        idle(0, 1'b0, 2, "ovl_idle");

        // Non-overlapping mode: only the first match counts.
        do_load(0, 4'b1011, 1'b0, 1'b0, 1'b0, "ld_novl");
        for (int i = 0; i < 7; i++)
            bit_in(0, b2[i][0], y3[i][0], c3[i], $sformatf("novl_b%0d", i + 1));

        // A different programmed pattern, overlapping.
        do_load(0, 4'b0110, 1'b1, 1'b0, 1'b0, "ld_0110");
        for (int i = 0; i < 7; i++)
            bit_in(0, b7[i][0], y7[i][0], c7[i], $sformatf("p0110_b%0d", i + 1));

        // Gapped stream: idle cycles with a toggling must be ignored.
        do_load(0, 4'b1011, 1'b1, 1'b0, 1'b0, "ld_gap");
        bit_in(0, 1'b1, 1'b0, 0, "gap_b1");
        idle(0, 1'b0, 0, "gap_i1");
        bit_in(0, 1'b0, 1'b0, 0, "gap_b2");
        idle(0, 1'b1, 0, "gap_i2");
        bit_in(0, 1'b1, 1'b0, 0, "gap_b3");
        idle(0, 1'b0, 0, "gap_i3");
        bit_in(0, 1'b1, 1'b1, 1, "gap_b4");
        idle(0, 1'b1, 1, "gap_i4");
        idle(0, 1'b0, 1, "gap_i5");

        // Partial 1,0,1 then a mid-cycle reset discards the history.
        bit_in(0, 1'b1, 1'b0, 1, "pre_b1");
        bit_in(0, 1'b0, 1'b0, 1, "pre_b2");
        bit_in(0, 1'b1, 1'b0, 1, "pre_b3");
        pulse_reset();
        bit_in(0, 1'b1, 1'b0, 0, "post_b1");
        bit_in(0, 1'b0, 1'b0, 0, "post_b2");
        bit_in(0, 1'b1, 1'b0, 0, "post_b3");
        bit_in(0, 1'b1, 1'b1, 1, "post_b4");

        // Load with valid=1: the bit on that edge is dropped.
        do_load(0, 4'b1011, 1'b1, 1'b1, 1'b1, "ld_valid");
        bit_in(0, 1'b0, 1'b0, 0, "ldv_b1");
        bit_in(0, 1'b1, 1'b0, 0, "ldv_b2");
        bit_in(0, 1'b1, 1'b0, 0, "ldv_b3");

        // 2-bit counter: back-to-back matches and saturation at 3.
        do_load(1, 4'b1111, 1'b1, 1'b0, 1'b0, "ld_1111");
        for (int i = 0; i < 8; i++)
            bit_in(1, 1'b1, y5[i][0], c5[i], $sformatf("sat_b%0d", i + 1));
        idle(1, 1'b0, 3, "sat_idle");
        do_load(1, 4'b1111, 1'b1, 1'b0, 1'b0, "ld_clr");

        // Let the monitors drain, bounded.
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain: pending entries actual=%0d required=0", qa.size() + qb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
